// File: rtl/shift_pkg.sv
// Shared encodings for the multi-cycle shifter: operation codes, FSM states
// and the mapping of the reserved op onto SLL.
package shift_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  function automatic op_e decode_op(input logic [1:0] raw);
    op_e res;
    case (raw)
      2'b01:   res = OP_SRL;
      2'b10:   res = OP_SRA;
      default: res = OP_SLL;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/shift_step.sv
// One-bit combinational shift of the working register; SRA refills from the
// sign bit captured at accept time.
module shift_step
  import shift_pkg::*;
#(
  parameter int BITWIDTH = 32
) (
  input  logic [BITWIDTH-1:0] data_i,
  input  op_e                 op_i,
  input  logic                sign_i,
  output logic [BITWIDTH-1:0] data_o
);

  // single-step shift selected by the captured op
  always_comb begin
    data_o = data_i;
    case (op_i)
      OP_SRL:  data_o = {1'b0, data_i[BITWIDTH-1:1]};
      OP_SRA:  data_o = {sign_i, data_i[BITWIDTH-1:1]};
      default: data_o = {data_i[BITWIDTH-2:0], 1'b0};
    endcase
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequential shifter: one bit per cycle, freezes the pipeline while busy and
// pulses done/sig_shifter for the writeback mux when the result is ready.
module shift_seq_ctrl
  import shift_pkg::*;
#(
  parameter int BITWIDTH = 32,
  parameter int SHW      = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [BITWIDTH-1:0] operand,
  input  logic [SHW-1:0]      shamt,
  output logic [BITWIDTH-1:0] result,
  output logic                busy,
  output logic                stall,
  output logic                done,
  output logic                sig_shifter
);

  state_e              state_q;
  op_e                 op_q;
  logic                sign_q;
  logic [SHW-1:0]      count_q;
  logic [BITWIDTH-1:0] result_q;
  logic [BITWIDTH-1:0] step_d;
  logic                busy_q;
  logic                done_q;
  logic                sig_q;

  shift_step #(
    .BITWIDTH(BITWIDTH)
  ) u_step (
    .data_i (result_q),
    .op_i   (op_q),
    .sign_i (sign_q),
    .data_o (step_d)
  );

  // FSM, shift counter and registered outputs; the result register doubles as
  // the working register and holds its value once DONE is reached
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= OP_SLL;
      sign_q   <= 1'b0;
      count_q  <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sig_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            result_q <= operand;
            op_q     <= decode_op(op);
            sign_q   <= operand[BITWIDTH-1];
            count_q  <= shamt;
            busy_q   <= 1'b1;
            if (shamt != '0) begin
              state_q <= SHIFT;
              done_q  <= 1'b0;
              sig_q   <= 1'b0;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
              sig_q   <= 1'b1;
            end
          end else begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            sig_q  <= 1'b0;
          end
        end
        SHIFT: begin
          result_q <= step_d;
          count_q  <= count_q - SHW'(1);
          if (count_q == SHW'(1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            sig_q   <= 1'b1;
          end else begin
            state_q <= SHIFT;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          sig_q   <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          sig_q   <= 1'b0;
        end
      endcase
    end
  end

  assign result      = result_q;
  assign busy        = busy_q;
  assign stall       = busy_q;
  assign done        = done_q;
  assign sig_shifter = sig_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed corner cases plus random
// shifts compared against a plain-arithmetic reference model.
module tb_shift_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand;
  logic [4:0]  shamt;
  logic [31:0] result;
  logic        busy;
  logic        stall;
  logic        done;
  logic        sig_shifter;

  int checks;
  int failures;

  shift_seq_ctrl #(
    .BITWIDTH(32),
    .SHW(5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .operand     (operand),
    .shamt       (shamt),
    .result      (result),
    .busy        (busy),
    .stall       (stall),
    .done        (done),
    .sig_shifter (sig_shifter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] v, input int s);
    logic [31:0] r;
    case (o)
      2'b01:   r = v >> s;
      2'b10:   r = 32'($signed(v) >>> s);
      default: r = v << s;
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic b, input logic d);
    chk({tag, " busy"}, {31'd0, busy}, {31'd0, b});
    chk({tag, " stall"}, {31'd0, stall}, {31'd0, b});
    chk({tag, " done"}, {31'd0, done}, {31'd0, d});
    chk({tag, " sig_shifter"}, {31'd0, sig_shifter}, {31'd0, d});
  endtask

  // Called at a negedge; start is accepted on the following posedge. Cycle k
  // is the k-th cycle after that edge: busy for k=1..s+1, done only at k=s+1,
  // then the result must hold one more cycle with busy low. Inputs are
  // scrambled every cycle while busy, and start is re-raised at glitch_k.
  task automatic do_shift(input string tag, input logic [1:0] o, input logic [31:0] v,
                          input logic [4:0] s, input int glitch_k);
    logic [31:0] exp;
    int          lat;
    exp     = model(o, v, int'(s));
    lat     = int'(s) + 1;
    start   = 1'b1;
    op      = o;
    operand = v;
    shamt   = s;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      chk_ctl(tag, 1'b1, (k == lat));
      if (k == lat) chk({tag, " result"}, result, exp);
      start   = (k == glitch_k);
      op      = 2'($urandom_range(0, 3));
      operand = $urandom;
      shamt   = 5'($urandom);
    end
    @(negedge clk);
    chk_ctl({tag, " after"}, 1'b0, 1'b0);
    chk({tag, " hold"}, result, exp);
    start = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    start    = 1'b0;
    op       = 2'b00;
    operand  = 32'd0;
    shamt    = 5'd0;
    repeat (2) @(negedge clk);
    chk_ctl("reset", 1'b0, 1'b0);
    chk("reset result", result, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_shift("sll1x4", 2'b00, 32'h0000_0001, 5'd4, 0);
    chk("sll1x4 literal", result, 32'h0000_0010);
    do_shift("sra31", 2'b10, 32'h8000_0000, 5'd31, 0);
    chk("sra31 literal", result, 32'hFFFF_FFFF);
    do_shift("srl31", 2'b01, 32'h8000_0000, 5'd31, 0);
    chk("srl31 literal", result, 32'h0000_0001);
    do_shift("sh0", 2'b01, 32'hDEAD_BEEF, 5'd0, 0);
    chk("sh0 literal", result, 32'hDEAD_BEEF);
    do_shift("ignore", 2'b01, 32'hF000_00F0, 5'd3, 2);
    chk("ignore literal", result, 32'h1E00_001E);
    @(negedge clk);
    // back-to-back: second start lands on the cycle right after DONE
    do_shift("b2b_a", 2'b10, 32'h8421_0000, 5'd2, 0);
    do_shift("b2b_b", 2'b11, 32'h0000_0003, 5'd5, 0);
    chk("rsv literal", result, 32'h0000_0060);

    // reset in the middle of an SRL by 10
    @(negedge clk);
    start   = 1'b1;
    op      = 2'b01;
    operand = 32'hFFFF_0000;
    shamt   = 5'd10;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      chk_ctl("pre_abort", 1'b1, 1'b0);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_ctl("abort", 1'b0, 1'b0);
    chk("abort result", result, 32'd0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk_ctl("post_abort", 1'b0, 1'b0);
    end
    do_shift("after_abort", 2'b01, 32'hFFFF_0000, 5'd10, 0);

    for (int i = 0; i < 10; i++) begin
      logic [4:0] rs;
      rs = 5'($urandom);
      do_shift("rand", 2'($urandom_range(0, 3)), $urandom, rs,
               (rs == 5'd0) ? 0 : int'($urandom_range(1, int'(rs) + 1)));
      if (i % 2 == 0) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 SHALL have parameter BITWIDTH, default 32, giving the operand/result width.
REQ-002 SHALL have parameter SHW, default 5, giving the shamt width; 2**SHW equals BITWIDTH.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a shift.
REQ-006 SHALL have port op  input  2  shift operation: 00 SLL, 01 SRL, 10 SRA, 11 reserved.
REQ-007 SHALL have port operand  input  BITWIDTH  value to shift (rt).
REQ-008 SHALL have port shamt  input  SHW  shift amount.
REQ-009 SHALL have port result  output  BITWIDTH  shifted value, feeding the shifter leg of the writeback mux.
REQ-010 SHALL have port busy  output  1  high while a shift is in progress.
REQ-011 SHALL have port stall  output  1  PC/pipeline freeze request.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port sig_shifter  output  1  writeback-mux select; 1 selects result over the ALU result.

Function
REQ-014 SHALL implement states IDLE, SHIFT and DONE.
REQ-015 SHALL, in IDLE with start=1, capture operand, op and shamt into internal registers; next state SHIFT if shamt!=0, else DONE.
REQ-016 SHALL, in SHIFT, shift the working register by one bit per cycle, decrement the remaining count, and enter DONE on the cycle the count reaches 0.
REQ-017 SHALL fill vacated bits as follows: SLL with 0 from the LSB, SRL with 0 from the MSB, SRA with a copy of the captured operand MSB.
REQ-018 SHALL treat op=11 exactly as SLL.
REQ-019 SHALL, in DONE, assert done=1 and sig_shifter=1 for exactly one cycle, then return to IDLE.
REQ-020 SHALL complete with latency shamt+1 cycles from the start edge to the done cycle; shamt=0 gives 1 cycle, and the result equals operand.
REQ-021 SHALL drive busy=1 in SHIFT and DONE, and stall=busy.
REQ-022 SHALL ignore start while busy=1, leaving the captured operands unchanged.
REQ-023 SHALL hold result stable from DONE until the next accepted start.
REQ-024 SHALL keep inputs sampled only at the accept edge; input changes during SHIFT SHALL have no effect.
REQ-025 SHALL accept a start asserted on the cycle after DONE, since the FSM is already in IDLE.

Reset
REQ-026 SHALL, on rst=1 at a clock edge, enter IDLE and clear result, count, busy, stall, done and sig_shifter to 0.
REQ-027 SHALL give rst priority over start and over any state transition, including mid-SHIFT; no done pulse is produced for an aborted shift.

Structure
REQ-028 SHALL take op encodings (OP_SLL, OP_SRL, OP_SRA) and state encodings from a shared package, shift_pkg.
REQ-029 SHALL use one sub-module, shift_step: a combinational one-bit shift of the working register by op.
REQ-030 SHALL contain no other sub-modules; the FSM and counter reside in shift_seq_ctrl.

Verification
REQ-031 SHALL cover: SLL, operand 0x0000_0001, shamt 4 -> done on the 5th cycle after start, result 0x0000_0010, sig_shifter high only in that cycle.
REQ-032 SHALL cover: SRA, operand 0x8000_0000, shamt 31 -> done after 32 cycles, result 0xFFFF_FFFF; stall high throughout.
REQ-033 SHALL cover: SRL, operand 0x8000_0000, shamt 31 -> result 0x0000_0001.
REQ-034 SHALL cover: shamt 0, operand 0xDEAD_BEEF -> done one cycle after start, result 0xDEAD_BEEF.
REQ-035 SHALL cover: a second start with different operands at cycle 2 of a 4-cycle shift -> ignored; the first result is correct and busy falls after DONE.
REQ-036 SHALL cover: rst asserted at cycle 3 of SRL shamt 10 -> next cycle IDLE with all outputs 0, no done pulse; a following start then operates normally.
